pulse_stretcher: RTL and testbench

- Turns a single-cycle event (for example, the positive_edge strobe of an edge detector) back into a clean level pulse of programmable length.
- Every pulse is followed by a guaranteed low gap, so a downstream edge detector sees exactly one rising edge per accepted event.
- Sits on the transmit side of control paths, for example ALU start/strobe lines, between a one-cycle event source and a registered sampler.

---
 rtl/pulse_stretcher.sv | 183 ++++++++++++++++++
 tb/tb_pulse_stretcher.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - one-cycle event to programmable-length level pulse with forced low gap
//
// Purpose:
//   Stretches an accepted trigger strobe into a clean high pulse of len_eff
//   cycles. Every pulse is followed by MIN_GAP low cycles, so a downstream
//   edge detector sees exactly one rising edge per accepted event. One
//   further trigger may be parked in a pending slot while busy. A trigger
//   that finds the slot already full is discarded and recorded in the
//   sticky drop_flag.
//
// Parameters:
//   LEN_W     - width of len and of the internal down-counter
//   MIN_GAP   - low cycles forced after every pulse (1 .. 2**LEN_W-1)
//   RETRIGGER - 1: trigger while ACTIVE reloads the counter (extends pulse)
//               0: trigger while ACTIVE goes to the pending slot
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   en        - trigger enable; trig is ignored (and never a drop) when low
//   trig      - event strobe, sampled every rising edge
//   len       - pulse length in cycles, sampled on accept; 0 acts as 1
//   clr_drop  - synchronous clear of drop_flag (loses to a same-edge drop)
//   pulse_out - registered stretched pulse
//   busy      - high while ACTIVE or GAP
//   done      - one-cycle strobe in the last GAP cycle of each pulse
//   drop_flag - sticky: an enabled trigger was discarded

module pulse_stretcher #(
    parameter int LEN_W     = 8,
    parameter int MIN_GAP   = 2,
    parameter bit RETRIGGER = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trig,
    input  logic [LEN_W-1:0] len,
    input  logic             clr_drop,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             drop_flag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] GAP_LAST = LEN_W'(MIN_GAP - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [LEN_W-1:0] plen_q, plen_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic             accept;
    logic             drop;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_m1;

    assign accept  = trig & en;
    assign len_eff = (len == '0) ? ONE : len;
    // Counter load value: the counter runs len_eff-1 .. 0, so a pulse of
    // 2**LEN_W-1 cycles still fits without wrapping.
    assign len_m1  = len_eff - ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        plen_d  = plen_q;
        drop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACTIVE;
                    cnt_d   = len_m1;
                end
            end

            S_ACTIVE: begin
                if (accept && RETRIGGER) begin
                    // Reload keeps pulse_out high: elapsed + new len_eff.
                    cnt_d = len_m1;
                end else begin
                    if (accept) begin
                        if (pend_q) begin
                            drop = 1'b1;
                        end else begin
                            pend_d = 1'b1;
                            plen_d = len_eff;
                        end
                    end
                    if (cnt_q == '0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end

            S_GAP: begin
                // A trigger on the exit edge with an empty slot is taken as
                // a fresh start below rather than parked.
                if (accept) begin
                    if (pend_q) begin
                        drop = 1'b1;
                    end else if (cnt_q != '0) begin
                        pend_d = 1'b1;
                        plen_d = len_eff;
                    end
                end
                if (cnt_q == '0) begin
                    if (pend_q) begin
                        state_d = S_ACTIVE;
                        cnt_d   = plen_q - ONE;
                        pend_d  = 1'b0;
                    end else if (accept) begin
                        state_d = S_ACTIVE;
                        cnt_d   = len_m1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        // Outputs are registered copies of what the next state implies, so
        // they line up with the state they describe with no extra latency.
        pulse_d = (state_d == S_ACTIVE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_GAP) && (cnt_d == '0);
        // A drop on the same edge as clr_drop wins.
        drop_d  = drop | (drop_q & ~clr_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            plen_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            plen_q  <= plen_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign drop_flag = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;

    logic       en0, trig0, clr0;
    logic [7:0] len0;
    logic       pulse0, busy0, done0, drop0;

    logic       en1, trig1, clr1;
    logic [7:0] len1;
    logic       pulse1, busy1, done1, drop1;

    int total;
    int bad;

    pulse_stretcher #(.LEN_W(8), .MIN_GAP(2), .RETRIGGER(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .en        (en0),
        .trig      (trig0),
        .len       (len0),
        .clr_drop  (clr0),
        .pulse_out (pulse0),
        .busy      (busy0),
        .done      (done0),
        .drop_flag (drop0)
    );

    pulse_stretcher #(.LEN_W(8), .MIN_GAP(2), .RETRIGGER(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en1),
        .trig      (trig1),
        .len       (len1),
        .clr_drop  (clr1),
        .pulse_out (pulse1),
        .busy      (busy1),
        .done      (done1),
        .drop_flag (drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Advance to the next cycle; inputs driven and outputs sampled 2 time
    // units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // One character per cycle. Trigger string: '.' = no trig, digit = trig
    // with that len. Expected strings: '0'/'1'.
    task automatic run_seq(input int sel, input string tag, input string t,
                           input string p, input string b, input string d,
                           input string f);
        byte c;
        for (int i = 0; i < t.len(); i++) begin
            logic po, bo, dn, dr;
            po = (sel == 0) ? pulse0 : pulse1;
            bo = (sel == 0) ? busy0  : busy1;
            dn = (sel == 0) ? done0  : done1;
            dr = (sel == 0) ? drop0  : drop1;
            check($sformatf("%s[%0d].pulse", tag, i), int'(po), (p[i] == "1") ? 1 : 0);
            check($sformatf("%s[%0d].busy",  tag, i), int'(bo), (b[i] == "1") ? 1 : 0);
            check($sformatf("%s[%0d].done",  tag, i), int'(dn), (d[i] == "1") ? 1 : 0);
            check($sformatf("%s[%0d].drop",  tag, i), int'(dr), (f[i] == "1") ? 1 : 0);
            c = t[i];
            if (sel == 0) begin
                trig0 = (c != ".");
                if (c != ".") len0 = 8'(c - 8'd48);
            end else begin
                trig1 = (c != ".");
                if (c != ".") len1 = 8'(c - 8'd48);
            end
            next_cycle();
        end
        trig0 = 1'b0;
        trig1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int guard;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en0 = 1'b1; trig0 = 1'b0; clr0 = 1'b0; len0 = 8'd0;
        en1 = 1'b1; trig1 = 1'b0; clr1 = 1'b0; len1 = 8'd0;

        repeat (2) next_cycle();
        check("reset.pulse", int'(pulse0), 0);
        check("reset.busy",  int'(busy0),  0);
        check("reset.done",  int'(done0),  0);
        check("reset.drop",  int'(drop0),  0);
        rst = 1'b0;
        next_cycle();

        // len=3: high 3 cycles one cycle after trig, busy 5, done in 5th.
        run_seq(0, "len3", ".3......",
                "00111000", "00111110", "00000010", "00000000");

        // len=0 acts as 1.
        run_seq(0, "len0", ".0.....",
                "0010000", "0011100", "0000100", "0000000");

        // Pending slot, then drop of a third trigger.
        run_seq(0, "pend", ".4.25........",
                "0011110011000", "0011111111110",
                "0000000100010", "0000011111111");
        clr0 = 1'b1;
        next_cycle();
        clr0 = 1'b0;
        check("clr_drop", int'(drop0), 0);

        // Retrigger extends the pulse without a gap.
        run_seq(1, "retrig", ".4.4.......",
                "00111111000", "00111111110",
                "00000000010", "00000000000");

        // en=0 blocks triggers entirely.
        en0 = 1'b0;
        run_seq(0, "en_off", ".3.3..",
                "000000", "000000", "000000", "000000");
        en0 = 1'b1;

        // Trigger on the GAP-exit edge restarts with no idle cycle.
        run_seq(0, "gapexit", ".2...1....",
                "0011001000", "0011111110",
                "0000010010", "0000000000");

        // Maximum length does not wrap the counter.
        trig0 = 1'b1;
        len0  = 8'd255;
        next_cycle();
        trig0 = 1'b0;
        hi    = 0;
        guard = 0;
        while (pulse0 && guard < 400) begin
            hi++;
            guard++;
            next_cycle();
        end
        check("len255.high", hi, 255);
        run_seq(0, "len255gap", "...",
                "000", "110", "010", "000");

        // Asynchronous reset mid-pulse with a pending entry.
        run_seq(0, "prerst", ".5.5.",
                "00111", "00111", "00000", "00000");
        check("prerst.pulse", int'(pulse0), 1);
        rst = 1'b1;
        #1;
        check("rst_async.pulse", int'(pulse0), 0);
        check("rst_async.busy",  int'(busy0),  0);
        check("rst_async.done",  int'(done0),  0);
        check("rst_async.drop",  int'(drop0),  0);
        next_cycle();
        rst = 1'b0;
        run_seq(0, "postrst", "............",
                "000000000000", "000000000000",
                "000000000000", "000000000000");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
